// File: rtl/car_fleet_if.sv
// rtl/car_fleet_if.sv - control inputs and car position outputs of the car_fleet engine
interface car_fleet_if #(
  parameter int NUM_AI = 3,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
);
  logic                    game_active;
  logic                    red_light;
  logic [1:0]              difficulty;
  logic [4*NUM_AI-1:0]     rand_val;
  logic                    move_up;
  logic                    move_down;
  logic                    move_forward;
  logic [X_W-1:0]          player_x;
  logic [Y_W-1:0]          player_y;
  logic [NUM_AI*X_W-1:0]   ai_x;
  logic [NUM_AI*Y_W-1:0]   ai_y;
  logic [NUM_AI:0]         finished;
  logic                    winner_valid;
  logic [2:0]              winner_id;
  logic                    violation;

  modport master (
    output game_active, red_light, difficulty, rand_val, move_up, move_down, move_forward,
    input  player_x, player_y, ai_x, ai_y, finished, winner_valid, winner_id, violation
  );

  modport slave (
    input  game_active, red_light, difficulty, rand_val, move_up, move_down, move_forward,
    output player_x, player_y, ai_x, ai_y, finished, winner_valid, winner_id, violation
  );
endinterface

// File: rtl/car_fleet.sv
// rtl/car_fleet.sv - player and AI car position engine with finish and winner tracking
module car_fleet #(
  parameter int NUM_AI      = 3,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int START_X     = 50,
  parameter int START_Y0    = 120,
  parameter int LANE_PITCH  = 100,
  parameter int PLAYER_DIV  = 2_500_000,
  parameter int AI_DIV      = 5_000_000,
  parameter int PLAYER_STEP = 5,
  parameter int AI_STEP     = 10,
  parameter int LAT_STEP    = 5,
  parameter int X_MAX       = 600,
  parameter int Y_MIN       = 50,
  parameter int Y_MAX       = 430,
  parameter int FINISH_X    = 580
) (
  input  logic       clk,
  input  logic       reset,
  car_fleet_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RACING = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam int PCW = (PLAYER_DIV > 1) ? $clog2(PLAYER_DIV) : 1;
  localparam int ACW = (AI_DIV > 1) ? $clog2(AI_DIV) : 1;
  localparam int XEW = X_W + 1;
  localparam int YEW = Y_W + 1;

  localparam logic [PCW-1:0] P_LAST   = PCW'(PLAYER_DIV - 1);
  localparam logic [ACW-1:0] A_LAST   = ACW'(AI_DIV - 1);
  localparam logic [X_W-1:0] XS       = X_W'(START_X);
  localparam logic [Y_W-1:0] YS0      = Y_W'(START_Y0);
  localparam logic [X_W:0]   XMAX_E   = XEW'(X_MAX);
  localparam logic [X_W:0]   XFIN_E   = XEW'(FINISH_X);
  localparam logic [X_W:0]   P_STEP_E = XEW'(PLAYER_STEP);
  localparam logic [X_W:0]   A_STEP_E = XEW'(AI_STEP);
  localparam logic [Y_W:0]   YMIN_E   = YEW'(Y_MIN);
  localparam logic [Y_W:0]   YMAX_E   = YEW'(Y_MAX);
  localparam logic [Y_W:0]   LAT_E    = YEW'(LAT_STEP);

  // Forward move, summed one bit wider so the clamp sees the true value.
  function automatic logic [X_W-1:0] x_fwd(input logic [X_W-1:0] x, input logic [X_W:0] step);
    logic [X_W:0] s;
    s = {1'b0, x} + step;
    return (s > XMAX_E) ? XMAX_E[X_W-1:0] : s[X_W-1:0];
  endfunction

  // Lateral move; up and down together cancel out.
  function automatic logic [Y_W-1:0] y_lat(input logic [Y_W-1:0] y, input logic up, input logic dn);
    logic [Y_W-1:0] r;
    r = y;
    if (up && !dn)
      r = ({1'b0, y} < YMIN_E + LAT_E) ? YMIN_E[Y_W-1:0] : y - LAT_E[Y_W-1:0];
    else if (dn && !up)
      r = ({1'b0, y} + LAT_E > YMAX_E) ? YMAX_E[Y_W-1:0] : y + LAT_E[Y_W-1:0];
    return r;
  endfunction

  function automatic logic [Y_W-1:0] ai_start_y(input int i);
    return Y_W'(START_Y0 + (i + 1) * LANE_PITCH);
  endfunction

  logic [1:0]     state;
  logic           ga_q;
  logic [1:0]     diff_q;
  logic [PCW-1:0] pcnt;
  logic [ACW-1:0] acnt;
  logic [X_W-1:0] px, px_n;
  logic [Y_W-1:0] py, py_n;
  logic [X_W-1:0] ax [NUM_AI];
  logic [X_W-1:0] ax_n [NUM_AI];
  logic [Y_W-1:0] ay [NUM_AI];
  logic [Y_W-1:0] ay_n [NUM_AI];
  logic [NUM_AI:0] finished, fin_n, hit;
  logic           winner_valid, win_n, violation, viol_n;
  logic [2:0]     winner_id, win_id_n;
  logic [3:0]     nib;
  logic           fwd_en;
  logic           p_tick, a_tick;

  assign p_tick = (state == RACING) && (pcnt == P_LAST);
  assign a_tick = (state == RACING) && (acnt == A_LAST);

  // Next positions for this cycle's ticks, plus finish and winner resolution.
  always_comb begin
    px_n   = px;
    py_n   = py;
    viol_n = 1'b0;
    nib    = 4'd0;
    fwd_en = 1'b0;
    if (p_tick) begin
      if (bus.red_light && bus.move_forward) begin
        px_n   = XS;
        viol_n = 1'b1;
      end else begin
        if (bus.move_forward) px_n = x_fwd(px, P_STEP_E);
        py_n = y_lat(py, bus.move_up, bus.move_down);
      end
    end
    for (int i = 0; i < NUM_AI; i++) begin
      ax_n[i] = ax[i];
      ay_n[i] = ay[i];
      nib = bus.rand_val[4*i +: 4];
      case (diff_q)
        2'd0:    fwd_en = &nib[1:0];
        2'd1:    fwd_en = nib[1];
        2'd2:    fwd_en = |nib[1:0];
        default: fwd_en = 1'b1;
      endcase
      if (a_tick) begin
        if (fwd_en && !bus.red_light) ax_n[i] = x_fwd(ax[i], A_STEP_E);
        ay_n[i] = y_lat(ay[i], nib[2], nib[3]);
      end
    end
    hit    = '0;
    hit[0] = ({1'b0, px_n} >= XFIN_E);
    for (int i = 0; i < NUM_AI; i++) hit[i+1] = ({1'b0, ax_n[i]} >= XFIN_E);
    fin_n    = finished | ((p_tick || a_tick) ? hit : '0);
    win_n    = (p_tick || a_tick) && (|fin_n);
    win_id_n = 3'd0;
    for (int k = NUM_AI; k >= 0; k--) if (fin_n[k]) win_id_n = 3'(k);
  end

  // Round FSM, tick counters and all registered car state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ga_q         <= 1'b0;
      diff_q       <= 2'd0;
      pcnt         <= '0;
      acnt         <= '0;
      px           <= XS;
      py           <= YS0;
      finished     <= '0;
      winner_valid <= 1'b0;
      winner_id    <= 3'd0;
      violation    <= 1'b0;
      for (int i = 0; i < NUM_AI; i++) begin
        ax[i] <= XS;
        ay[i] <= ai_start_y(i);
      end
    end else begin
      ga_q      <= bus.game_active;
      violation <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.game_active && !ga_q) begin
            state        <= RACING;
            diff_q       <= bus.difficulty;
            pcnt         <= '0;
            acnt         <= '0;
            px           <= XS;
            py           <= YS0;
            finished     <= '0;
            winner_valid <= 1'b0;
            winner_id    <= 3'd0;
            for (int i = 0; i < NUM_AI; i++) begin
              ax[i] <= XS;
              ay[i] <= ai_start_y(i);
            end
          end
        end
        RACING: begin
          if (!bus.game_active) begin
            state <= IDLE;
          end else begin
            pcnt      <= p_tick ? '0 : pcnt + 1'b1;
            acnt      <= a_tick ? '0 : acnt + 1'b1;
            px        <= px_n;
            py        <= py_n;
            violation <= viol_n;
            finished  <= fin_n;
            for (int i = 0; i < NUM_AI; i++) begin
              ax[i] <= ax_n[i];
              ay[i] <= ay_n[i];
            end
            if (win_n) begin
              winner_valid <= 1'b1;
              winner_id    <= win_id_n;
              state        <= DONE;
            end
          end
        end
        default: begin
          if (!bus.game_active) state <= IDLE;
        end
      endcase
    end
  end

  assign bus.player_x     = px;
  assign bus.player_y     = py;
  assign bus.finished     = finished;
  assign bus.winner_valid = winner_valid;
  assign bus.winner_id    = winner_id;
  assign bus.violation    = violation;

  for (genvar g = 0; g < NUM_AI; g++) begin : g_pack
    assign bus.ai_x[g*X_W +: X_W] = ax[g];
    assign bus.ai_y[g*Y_W +: Y_W] = ay[g];
  end
endmodule

// File: tb/tb_car_fleet.sv
// tb/tb_car_fleet.sv - scoreboard bench for car_fleet with short tick dividers
module tb_car_fleet;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  car_fleet_if #(.NUM_AI(3), .X_W(10), .Y_W(9)) bus ();
  car_fleet #(.NUM_AI(3), .PLAYER_DIV(4), .AI_DIV(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RACING = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_round(input logic [1:0] diff);
    bus.difficulty  = diff;
    bus.game_active = 1'b0;
    step(1);
    bus.game_active = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.game_active = 0; bus.red_light = 0; bus.difficulty = 0; bus.rand_val = '0;
    bus.move_up = 0; bus.move_down = 0; bus.move_forward = 0;
    step(2);
    checks++; if (bus.player_x !== 10'd50 || bus.player_y !== 9'd120) begin errors++;
      $display("FAIL reset_player: got (%0d,%0d) expected (50,120)", bus.player_x, bus.player_y); end
    checks++; if (bus.ai_x !== {3{10'd50}}) begin errors++;
      $display("FAIL reset_ai_x: got %h expected %h", bus.ai_x, {3{10'd50}}); end
    checks++; if (bus.ai_y !== {9'd420, 9'd320, 9'd220}) begin errors++;
      $display("FAIL reset_ai_y: got %h expected %h", bus.ai_y, {9'd420, 9'd320, 9'd220}); end
    checks++; if ({bus.finished, bus.winner_valid, bus.winner_id, bus.violation} !== 9'd0) begin errors++;
      $display("FAIL reset_flags: got fin=%b wv=%b wid=%0d v=%b expected all 0", bus.finished, bus.winner_valid, bus.winner_id, bus.violation); end
    checks++; if (dut.state !== S_IDLE) begin errors++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state, S_IDLE); end
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_start();
    bus.move_forward = 1'b1;
    start_round(2'd0);
    checks++; if (dut.state !== S_RACING || bus.player_x !== 10'd50 || bus.player_y !== 9'd120) begin errors++;
      $display("FAIL start_pos: got st=%0d (%0d,%0d) expected st=1 (50,120)", dut.state, bus.player_x, bus.player_y); end
    step(3);
    checks++; if (bus.player_x !== 10'd50) begin errors++;
      $display("FAIL before_first_tick: got %0d expected 50", bus.player_x); end
    step(1);
    checks++; if (bus.player_x !== 10'd55) begin errors++;
      $display("FAIL first_tick: got %0d expected 55", bus.player_x); end
  endtask

  task automatic test_player_forward();
    logic [9:0] ex;
    for (int v = 60; v <= 580; v += 5) exp_q.push_back(v);
    while (exp_q.size() > 0) begin
      step(4);
      ex = 10'(exp_q.pop_front());
      checks++; if (bus.player_x !== ex) begin errors++;
        $display("FAIL player_fwd: got %0d expected %0d", bus.player_x, ex); end
    end
    checks++; if (bus.finished !== 4'b0001 || bus.winner_valid !== 1'b1 || bus.winner_id !== 3'd0) begin errors++;
      $display("FAIL player_win: got fin=%b wv=%b wid=%0d expected 0001 1 0", bus.finished, bus.winner_valid, bus.winner_id); end
    checks++; if (dut.state !== S_DONE || bus.ai_x !== {3{10'd50}}) begin errors++;
      $display("FAIL player_done: got st=%0d ai_x=%h expected st=2 ai_x=%h", dut.state, bus.ai_x, {3{10'd50}}); end
    step(12);
    checks++; if (bus.player_x !== 10'd580 || dut.state !== S_DONE) begin errors++;
      $display("FAIL frozen: got x=%0d st=%0d expected 580 2", bus.player_x, dut.state); end
  endtask

  task automatic test_red_violation();
    bus.move_forward = 1'b1;
    bus.red_light = 1'b0;
    start_round(2'd3);
    step(40);
    checks++; if (bus.player_x !== 10'd100 || bus.ai_x !== {3{10'd100}}) begin errors++;
      $display("FAIL green_run: got px=%0d ai_x=%h expected 100 %h", bus.player_x, bus.ai_x, {3{10'd100}}); end
    bus.red_light = 1'b1;
    step(3);
    checks++; if (bus.violation !== 1'b0 || bus.player_x !== 10'd100) begin errors++;
      $display("FAIL pre_violation: got v=%b px=%0d expected 0 100", bus.violation, bus.player_x); end
    step(1);
    checks++; if (bus.violation !== 1'b1 || bus.player_x !== 10'd50) begin errors++;
      $display("FAIL violation: got v=%b px=%0d expected 1 50", bus.violation, bus.player_x); end
    step(1);
    checks++; if (bus.violation !== 1'b0) begin errors++;
      $display("FAIL violation_pulse: got %b expected 0", bus.violation); end
    step(3);
    checks++; if (bus.ai_x !== {3{10'd100}} || bus.player_x !== 10'd50) begin errors++;
      $display("FAIL red_ai_hold: got ai_x=%h px=%0d expected %h 50", bus.ai_x, bus.player_x, {3{10'd100}}); end
    bus.red_light = 1'b0;
    bus.move_forward = 1'b0;
  endtask

  task automatic test_ai_forward();
    logic [9:0] ex;
    bus.move_forward = 1'b0;
    bus.rand_val = '0;
    start_round(2'd3);
    for (int v = 60; v <= 580; v += 10) exp_q.push_back(v);
    while (exp_q.size() > 0) begin
      step(8);
      ex = 10'(exp_q.pop_front());
      checks++; if (bus.ai_x !== {ex, ex, ex}) begin errors++;
        $display("FAIL ai_fwd: got %h expected %h", bus.ai_x, {ex, ex, ex}); end
    end
    checks++; if (bus.finished !== 4'b1110 || bus.winner_valid !== 1'b1 || bus.winner_id !== 3'd1) begin errors++;
      $display("FAIL ai_win: got fin=%b wv=%b wid=%0d expected 1110 1 1", bus.finished, bus.winner_valid, bus.winner_id); end
    checks++; if (bus.player_x !== 10'd50) begin errors++;
      $display("FAIL ai_race_player: got %0d expected 50", bus.player_x); end
  endtask

  task automatic test_lateral();
    logic [8:0] ey;
    bus.rand_val = {4'b1000, 4'b1000, 4'b0100};
    start_round(2'd0);
    checks++; if (bus.finished !== 4'b0000 || bus.winner_valid !== 1'b0) begin errors++;
      $display("FAIL restart_clear: got fin=%b wv=%b expected 0000 0", bus.finished, bus.winner_valid); end
    bus.move_up = 1'b1;
    bus.move_down = 1'b1;
    step(4);
    checks++; if (bus.player_y !== 9'd120) begin errors++;
      $display("FAIL up_and_down: got %0d expected 120", bus.player_y); end
    bus.move_down = 1'b0;
    for (int v = 115; v >= 50; v -= 5) exp_q.push_back(v);
    exp_q.push_back(50);
    exp_q.push_back(50);
    while (exp_q.size() > 0) begin
      step(4);
      ey = 9'(exp_q.pop_front());
      checks++; if (bus.player_y !== ey) begin errors++;
        $display("FAIL player_up: got %0d expected %0d", bus.player_y, ey); end
    end
    checks++; if (bus.ai_y !== {9'd430, 9'd360, 9'd180} || bus.ai_x !== {3{10'd50}}) begin errors++;
      $display("FAIL ai_lateral: got ai_y=%h ai_x=%h expected %h %h", bus.ai_y, bus.ai_x, {9'd430, 9'd360, 9'd180}, {3{10'd50}}); end
    bus.move_up = 1'b0;
  endtask

  task automatic test_restart();
    bus.rand_val = '0;
    bus.move_forward = 1'b1;
    start_round(2'd2);
    step(8);
    checks++; if (bus.player_x !== 10'd60 || bus.ai_x !== {3{10'd50}}) begin errors++;
      $display("FAIL diff2_run: got px=%0d ai_x=%h expected 60 %h", bus.player_x, bus.ai_x, {3{10'd50}}); end
    bus.game_active = 1'b0;
    step(1);
    checks++; if (dut.state !== S_IDLE || bus.player_x !== 10'd60) begin errors++;
      $display("FAIL drop_idle: got st=%0d px=%0d expected 0 60", dut.state, bus.player_x); end
    step(5);
    checks++; if (bus.player_x !== 10'd60) begin errors++;
      $display("FAIL idle_hold: got %0d expected 60", bus.player_x); end
    bus.difficulty = 2'd3;
    bus.game_active = 1'b1;
    step(1);
    checks++; if (dut.state !== S_RACING || bus.player_x !== 10'd50 || bus.finished !== 4'b0000) begin errors++;
      $display("FAIL rise_restart: got st=%0d px=%0d fin=%b expected 1 50 0000", dut.state, bus.player_x, bus.finished); end
    step(8);
    checks++; if (bus.ai_x !== {3{10'd60}} || bus.player_x !== 10'd60) begin errors++;
      $display("FAIL relatch_diff: got ai_x=%h px=%0d expected %h 60", bus.ai_x, bus.player_x, {3{10'd60}}); end
    #2 reset = 1'b0;
    #1;
    checks++; if (dut.state !== S_IDLE || bus.player_x !== 10'd50 || bus.ai_x !== {3{10'd50}}) begin errors++;
      $display("FAIL async_reset: got st=%0d px=%0d ai_x=%h expected 0 50 %h", dut.state, bus.player_x, bus.ai_x, {3{10'd50}}); end
    bus.game_active = 1'b0;
    bus.move_forward = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_start();
    test_player_forward();
    test_red_violation();
    test_ai_forward();
    test_lateral();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
